// File: rtl/nv_stream_demux2_pkg.sv
// nv_stream_demux2_pkg
// Shared definitions for the packet-aware 1-to-2 stream demultiplexer:
// route FSM state encoding and per-output buffer depth.
package nv_stream_demux2_pkg;

  typedef enum logic {
    NV_DMX_IDLE = 1'b0,
    NV_DMX_LOCK = 1'b1
  } nv_dmx_state_e;

  localparam int unsigned NV_DMX_DEPTH = 2;

endpackage

// File: rtl/nv_stream_demux_fifo2.sv
// nv_stream_demux_fifo2
// Two-entry FIFO used as the per-output buffer of nv_stream_demux2.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO, clears storage)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   dout       : head entry
//   count      : number of stored entries (0..2)
module nv_stream_demux_fifo2
  import nv_stream_demux2_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [NV_DMX_DEPTH];
  logic [W-1:0] mem_d [NV_DMX_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    do_push  = push && (count_q < 2'(NV_DMX_DEPTH));
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
    end
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/nv_stream_demux2.sv
// nv_stream_demux2
// Packet-aware 1-to-2 valid/ready stream demultiplexer. The route is taken
// from in_sel on a packet's first beat and held until the in_last beat.
// Each output has its own 2-entry buffer so a stalled output never blocks
// traffic routed to the other one.
// Ports:
//   nvdla_core_clk, nvdla_core_rst : clock, synchronous active-high reset
//   in_pvld/in_prdy/in_pd/in_sel/in_last : input stream and route select
//   outN_pvld/outN_prdy/outN_pd/outN_last : output streams (N = 0, 1)
//   pkt_cnt0/pkt_cnt1 : packets fully accepted per output (wrapping)
//   busy : mid-packet, or either buffer holds data
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | between packets; the current beat routes by in_sel
// LOCK  | inside a multi-beat packet; beats route by lock_sel
module nv_stream_demux2
  import nv_stream_demux2_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [DW-1:0]    in_pd,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_pvld,
  input  logic             out0_prdy,
  output logic [DW-1:0]    out0_pd,
  output logic             out0_last,
  output logic             out1_pvld,
  input  logic             out1_prdy,
  output logic [DW-1:0]    out1_pd,
  output logic             out1_last,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             busy
);

  nv_dmx_state_e    state_q, state_d;
  logic             lock_sel_q, lock_sel_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  logic       tgt, acc;
  logic       push0, push1, pop0, pop1;
  logic [1:0] cnt0, cnt1;

  always_comb begin
    tgt     = (state_q == NV_DMX_LOCK) ? lock_sel_q : in_sel;
    // Ready depends only on the target buffer's occupancy, never on outN_prdy.
    in_prdy = tgt ? (cnt1 < 2'(NV_DMX_DEPTH)) : (cnt0 < 2'(NV_DMX_DEPTH));
    acc     = in_pvld && in_prdy;
    push0   = acc && !tgt;
    push1   = acc && tgt;

    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (state_q == NV_DMX_IDLE) begin
      if (acc && !in_last) begin
        state_d    = NV_DMX_LOCK;
        lock_sel_d = in_sel;
      end
    end else begin
      if (acc && in_last) begin
        state_d = NV_DMX_IDLE;
      end
    end

    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (acc && in_last) begin
      if (tgt) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
      else     pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= NV_DMX_IDLE;
      lock_sel_q <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign out0_pvld = (cnt0 != 2'd0);
  assign out1_pvld = (cnt1 != 2'd0);
  assign pop0      = out0_pvld && out0_prdy;
  assign pop1      = out1_pvld && out1_prdy;

  nv_stream_demux_fifo2 #(.W(DW + 1)) u_fifo0 (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (push0),
    .pop   (pop0),
    .din   ({in_pd, in_last}),
    .dout  ({out0_pd, out0_last}),
    .count (cnt0)
  );

  nv_stream_demux_fifo2 #(.W(DW + 1)) u_fifo1 (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (push1),
    .pop   (pop1),
    .din   ({in_pd, in_last}),
    .dout  ({out1_pd, out1_last}),
    .count (cnt1)
  );

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign busy     = (state_q == NV_DMX_LOCK) || out0_pvld || out1_pvld;

endmodule
